// File: rtl/readout_tx_pulse_generator_if.sv
// readout_tx_pulse_generator_if: host write ports, trigger and sample stream of the readout TX pulse generator
interface readout_tx_pulse_generator_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int ENV_ADDR_WIDTH = 8
);
  logic                        env_wr_en;
  logic [ENV_ADDR_WIDTH-1:0]   env_wr_addr;
  logic [2*DATA_WIDTH-1:0]     env_wr_data;
  logic                        cfg_wr_en;
  logic                        cfg_wr_addr;
  logic [DATA_WIDTH-1:0]       cfg_wr_data;
  logic                        trigger_in;
  logic                        busy;
  logic                        trigger_overrun;
  logic                        valid_out;
  logic [DATA_WIDTH-1:0]       i_out;
  logic [DATA_WIDTH-1:0]       q_out;
  logic                        start_count_out;
  logic                        finish_count_out;
  modport master (
    output env_wr_en, env_wr_addr, env_wr_data, cfg_wr_en, cfg_wr_addr, cfg_wr_data, trigger_in,
    input  busy, trigger_overrun, valid_out, i_out, q_out, start_count_out, finish_count_out
  );
  modport slave (
    input  env_wr_en, env_wr_addr, env_wr_data, cfg_wr_en, cfg_wr_addr, cfg_wr_data, trigger_in,
    output busy, trigger_overrun, valid_out, i_out, q_out, start_count_out, finish_count_out
  );
endinterface

// File: rtl/readout_tx_pulse_generator.sv
// readout_tx_pulse_generator: plays a stored I/Q envelope scaled by a live amplitude, framed by start/finish markers
module readout_tx_pulse_generator #(
  parameter int DATA_WIDTH     = 16,
  parameter int ENV_ADDR_WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst,
  readout_tx_pulse_generator_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam int A = ENV_ADDR_WIDTH;
  localparam int P = 2 * DATA_WIDTH;
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state;
  logic [A-1:0] rd_addr, last_addr, shadow_last;
  logic signed [W-1:0] amplitude;
  logic [P-1:0] mem [2**A];
  logic [P-1:0] rd_data;
  logic s1_valid, s1_start, s1_finish;
  logic s2_valid, s2_start, s2_finish;
  logic [W:0] top_i, top_q;
  // Q1.(W-1) product keeping bits [P-1:W-1]; the arithmetic shift floors, matching a plain bit-slice truncation
  function automatic logic [W:0] mul_top(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [P-1:0] p;
    p = P'(a) * P'(b);
    return (W+1)'(p >>> (W-1));
  endfunction
  // Only -max * -max reaches +1.0; the top two bits 01 flag it and it clamps to the largest positive value
  function automatic logic [W-1:0] sat(input logic [W:0] t);
    return t[W:W-1] == 2'b01 ? {1'b0, {(W-1){1'b1}}} : t[W-1:0];
  endfunction
  // Envelope RAM: read-before-write so a same-address write returns the old word; never cleared
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (bus.env_wr_en) mem[bus.env_wr_addr] <= bus.env_wr_data;
  end
  // Config registers; amplitude is consumed live, last_addr only at trigger acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      amplitude <= '0;
      last_addr <= '0;
    end else if (bus.cfg_wr_en) begin
      if (bus.cfg_wr_addr) last_addr <= bus.cfg_wr_data[A-1:0];
      else amplitude <= bus.cfg_wr_data;
    end
  end
  // Playback FSM plus stage-1 tags that travel with the memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_addr         <= '0;
      shadow_last     <= '0;
      bus.busy        <= 1'b0;
      bus.trigger_overrun <= 1'b0;
      s1_valid        <= 1'b0;
      s1_start        <= 1'b0;
      s1_finish       <= 1'b0;
    end else begin
      s1_valid  <= state == PLAY;
      s1_start  <= state == PLAY && rd_addr == '0;
      s1_finish <= state == PLAY && rd_addr == shadow_last;
      if (state == IDLE) begin
        if (bus.trigger_in) begin
          state       <= PLAY;
          rd_addr     <= '0;
          shadow_last <= last_addr;
          bus.busy    <= 1'b1;
        end
      end else begin
        rd_addr <= rd_addr + 1'b1;
        if (bus.trigger_in) bus.trigger_overrun <= 1'b1;
        if (rd_addr == shadow_last) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      end
    end
  end
  // Stage 2: registered multiply by the current amplitude
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_start  <= 1'b0;
      s2_finish <= 1'b0;
      top_i     <= '0;
      top_q     <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_start  <= s1_start;
      s2_finish <= s1_finish;
      top_i     <= mul_top(rd_data[P-1:W], amplitude);
      top_q     <= mul_top(rd_data[W-1:0], amplitude);
    end
  end
  // Output register: saturate, and hold data and markers at zero outside valid cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_out        <= 1'b0;
      bus.i_out            <= '0;
      bus.q_out            <= '0;
      bus.start_count_out  <= 1'b0;
      bus.finish_count_out <= 1'b0;
    end else begin
      bus.valid_out        <= s2_valid;
      bus.i_out            <= s2_valid ? sat(top_i) : '0;
      bus.q_out            <= s2_valid ? sat(top_q) : '0;
      bus.start_count_out  <= s2_valid && s2_start;
      bus.finish_count_out <= s2_valid && s2_finish;
    end
  end
endmodule
